// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, memory op codes and arbiter state encoding for the
// data-memory arbiter slice.
package dmem_arbiter_pkg;

   localparam int ADDR_WIDTH  = 32;
   localparam int DATA_WIDTH  = 32;
   localparam int MEM_OP_BITS = 2;

   localparam logic [MEM_OP_BITS-1:0] MEM_OP_NOP   = 2'd0;
   localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 2'd1;
   localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 2'd2;

   typedef enum logic [1:0] {
      ARB_ST_IDLE   = 2'd0,
      ARB_ST_ACCESS = 2'd1,
      ARB_ST_RESP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone requester always wins, on contention
// rr_ptr decides and afterwards points at the loser.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       grant_idx
);

   logic rr_ptr;

   always_comb begin
      grant_idx = rr_ptr;
      if (req == 2'b01) begin
         grant_idx = 1'b0;
      end else if (req == 2'b10) begin
         grant_idx = 1'b1;
      end
      grant = '0;
      if (|req) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= 1'b0;
      end else if (advance && |req) begin
         rr_ptr <= ~grant_idx;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the core LSU (port 0) and DMA (port 1) onto one data-memory
// port: accept, one ACCESS cycle, one RESP cycle that can accept the next.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_WIDTH,
   parameter int DATA_W = DATA_WIDTH,
   parameter int OP_W   = MEM_OP_BITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*OP_W-1:0]   req_op,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [OP_W-1:0]     mem_op,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam logic [OP_W-1:0] OP_NOP   = OP_W'(MEM_OP_NOP);
   localparam logic [OP_W-1:0] OP_READ  = OP_W'(MEM_OP_READ);
   localparam logic [OP_W-1:0] OP_WRITE = OP_W'(MEM_OP_WRITE);

   arb_state_t      state, state_nxt;
   logic [1:0]      rr_grant;
   logic            rr_idx;
   logic            arb_open;
   logic            accept;
   logic            win;
   logic [OP_W-1:0] lat_op;
   logic            lat_read, lat_write;

   // Gating with reset_n keeps req_ready low while reset is held.
   assign arb_open  = reset_n && (state != ARB_ST_ACCESS);
   assign lat_read  = (lat_op == OP_READ);
   assign lat_write = (lat_op == OP_WRITE);

   rr_arbiter2 u_rr (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req_valid),
      .advance   (arb_open),
      .grant     (rr_grant),
      .grant_idx (rr_idx)
   );

   always_comb begin
      req_ready = arb_open ? rr_grant : '0;
      accept    = |req_ready;
      state_nxt = state;
      mem_op    = OP_NOP;
      rsp_valid = '0;
      case (state)
         ARB_ST_IDLE: begin
            if (accept) state_nxt = ARB_ST_ACCESS;
         end
         ARB_ST_ACCESS: begin
            state_nxt = ARB_ST_RESP;
            if (lat_read || lat_write) mem_op = lat_op;
         end
         ARB_ST_RESP: begin
            rsp_valid[win] = 1'b1;
            state_nxt      = accept ? ARB_ST_ACCESS : ARB_ST_IDLE;
         end
         default: state_nxt = ARB_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ARB_ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // mem_addr/mem_wdata are the request latch itself, so they hold between accesses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win       <= 1'b0;
         lat_op    <= OP_NOP;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (accept) begin
         win       <= rr_idx;
         lat_op    <= rr_idx ? req_op[2*OP_W-1:OP_W]       : req_op[OP_W-1:0];
         mem_addr  <= rr_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
         mem_wdata <= rr_idx ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (state == ARB_ST_ACCESS) begin
         rsp_rdata <= lat_read ? mem_rdata : '0;
         rsp_err   <= !(lat_read || lat_write);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a cycle-timestamp transaction model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [3:0]  req_op    = '0;
   logic [63:0] req_addr  = '0;
   logic [63:0] req_wdata = '0;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_op;
   logic [31:0] mem_rdata = '0;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .OP_W(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_op    (mem_op),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted request occupies the memory port in the
   // following cycle and responds in the one after; no accept right after an accept.
   int          t_acc   = -10;
   bit          t_win   = 1'b0;
   logic [1:0]  t_op    = 2'd0;
   bit          m_rr    = 1'b0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdata = '0;
   bit          m_err   = 1'b0;

   always @(negedge clk) begin : cmp
      logic [1:0] e_ready;
      logic [1:0] e_op;
      logic [1:0] e_rv;
      bit         w;
      if (!reset_n) begin
         chk("rst_ready", req_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rdata", rsp_rdata, 0);
         chk("rst_err", rsp_err, 0);
         chk("rst_mem_op", mem_op, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_wdata", mem_wdata, 0);
         t_acc = -10; m_rr = 1'b0; m_addr = '0; m_wdata = '0;
      end else begin
         e_op = 2'd0;
         if (cyc == t_acc + 1 && (t_op == 2'd1 || t_op == 2'd2)) e_op = t_op;
         chk("m_mem_op", mem_op, e_op);
         chk("m_mem_addr", mem_addr, m_addr);
         chk("m_mem_wdata", mem_wdata, m_wdata);
         if (cyc == t_acc + 1) begin
            m_rdata = (t_op == 2'd1) ? mem_rdata : 32'd0;
            m_err   = !(t_op == 2'd1 || t_op == 2'd2);
         end
         e_rv = 2'b00;
         if (cyc == t_acc + 2) e_rv[t_win] = 1'b1;
         chk("m_rsp_valid", rsp_valid, e_rv);
         if (|e_rv) begin
            chk("m_rsp_rdata", rsp_rdata, m_rdata);
            chk("m_rsp_err", rsp_err, m_err);
         end
         e_ready = 2'b00;
         if (cyc != t_acc + 1 && |req_valid) begin
            w          = (req_valid == 2'b11) ? m_rr : req_valid[1];
            e_ready[w] = 1'b1;
            m_rr       = !w;
            t_acc      = cyc;
            t_win      = w;
            t_op       = req_op[w*2 +: 2];
            m_addr     = req_addr[w*32 +: 32];
            m_wdata    = req_wdata[w*32 +: 32];
         end
         chk("m_req_ready", req_ready, e_ready);
      end
   end

   task automatic set_req(input int i, input logic v, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] d);
      req_valid[i]        = v;
      req_op[i*2 +: 2]    = op;
      req_addr[i*32 +: 32] = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   task automatic wait_neg();
      @(negedge clk); #1;
   endtask

   task automatic to_pos();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #2 reset_n = 1'b1;
   endtask

   logic [1:0] rr_seq [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
   logic [1:0] vtab [16]  = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01,
                              2'b00, 2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11};
   logic [1:0] otab [8]   = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      logic [1:0] got;
      #1 reset_n = 1'b0;
      @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;

      // Single read after reset
      set_req(0, 1'b1, 2'd1, 32'h10, 32'h0);
      mem_rdata = 32'hCAFE;
      wait_neg(); chk("rd_ready", req_ready, 2'b01);
      to_pos(); req_valid = 2'b00;
      wait_neg(); chk("rd_mem_op", mem_op, 2'd1); chk("rd_mem_addr", mem_addr, 32'h10);
      wait_neg(); chk("rd_rsp_valid", rsp_valid, 2'b01); chk("rd_rsp_rdata", rsp_rdata, 32'hCAFE);
      repeat (2) to_pos();

      // Continuous contention after reset: grants alternate every 2 cycles
      do_reset();
      set_req(0, 1'b1, 2'd1, 32'h30, 32'h0);
      set_req(1, 1'b1, 2'd1, 32'h40, 32'h0);
      mem_rdata = 32'h5555;
      for (int j = 0; j < 8; j++) begin
         wait_neg(); chk($sformatf("rr_seq%0d", j), req_ready, rr_seq[j]);
      end
      to_pos(); req_valid = 2'b00;
      repeat (2) to_pos();

      // Write from DMA
      set_req(0, 1'b0, 2'd1, 32'h77, 32'h9999);
      set_req(1, 1'b1, 2'd2, 32'h20, 32'h1234);
      mem_rdata = 32'hDEAD;
      wait_neg(); chk("wr_ready", req_ready, 2'b10);
      to_pos(); req_valid = 2'b00;
      wait_neg();
      chk("wr_mem_op", mem_op, 2'd2);
      chk("wr_mem_addr", mem_addr, 32'h20);
      chk("wr_mem_wdata", mem_wdata, 32'h1234);
      wait_neg();
      chk("wr_rsp_valid", rsp_valid, 2'b10);
      chk("wr_rsp_rdata", rsp_rdata, 32'h0);
      chk("wr_resp_mem_op", mem_op, 2'd0);
      chk("wr_hold_addr", mem_addr, 32'h20);
      repeat (2) to_pos();

      // Illegal op 3 from LSU
      set_req(0, 1'b1, 2'd3, 32'h50, 32'h0);
      mem_rdata = 32'hBEEF;
      wait_neg(); chk("ill_ready", req_ready, 2'b01);
      to_pos(); req_valid = 2'b00;
      wait_neg(); chk("ill_mem_op", mem_op, 2'd0);
      wait_neg();
      chk("ill_rsp_valid", rsp_valid, 2'b01);
      chk("ill_rsp_err", rsp_err, 1'b1);
      chk("ill_rsp_rdata", rsp_rdata, 32'h0);
      repeat (2) to_pos();

      // Mixed traffic; payload changes only once its request was accepted
      for (int k = 0; k < 40; k++) begin
         wait_neg(); got = req_ready;
         to_pos();
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i] || got[i])
               set_req(i, vtab[(k + i*5) % 16][i], otab[(k*3 + i) % 8],
                       32'(32'h100 + k*4 + i), 32'(32'h1000*i + k));
         end
         mem_rdata = 32'(32'hA000 + k);
      end
      req_valid = 2'b00;
      repeat (3) to_pos();

      // Reset during ACCESS abandons the transaction and clears rr_ptr
      set_req(0, 1'b1, 2'd1, 32'h60, 32'h0);
      set_req(1, 1'b0, 2'd1, 32'h64, 32'h0);
      mem_rdata = 32'h1111;
      wait_neg(); chk("rst_acc_ready", req_ready, 2'b01);
      to_pos(); req_valid = 2'b00;
      chk("rst_acc_mem_op_pre", mem_op, 2'd1);
      #1 reset_n = 1'b0;
      #1 chk("rst_acc_mem_op", mem_op, 2'd0);
      @(posedge clk); #2 reset_n = 1'b1;
      for (int j = 0; j < 3; j++) begin
         wait_neg();
         chk($sformatf("rst_after_rv%0d", j), rsp_valid, 2'b00);
         chk($sformatf("rst_after_op%0d", j), mem_op, 2'd0);
      end
      to_pos(); req_valid = 2'b11;
      wait_neg(); chk("rst_rr_ptr", req_ready, 2'b01);
      to_pos(); req_valid = 2'b00;
      repeat (3) to_pos();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
